psg_stereo_dac: RTL and testbench



---
 rtl/psg_stereo_dac.sv | 184 ++++++++++++++++++
 tb/tb_psg_stereo_dac.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psg_stereo_dac.sv
// PSG stereo mixer with click-free gain ramp and
// first-order sigma-delta outputs for the board audio pins.
module psg_stereo_dac #(
  parameter int         RAMP_DIV   = 64,
  parameter logic [1:0] RESET_MODE = 2'b01
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clken,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] c,
  input  logic [1:0] stereo_mode,
  input  logic       mute,
  output logic [9:0] left_pcm,
  output logic [9:0] right_pcm,
  output logic       left_out,
  output logic       right_out,
  output logic       busy
);

  localparam int CW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [CW-1:0] CMAX = CW'(RAMP_DIV - 1);

  typedef enum logic [2:0] {
    S_RUN,
    S_FADE_OUT,
    S_MUTED,
    S_SWITCH,
    S_FADE_IN
  } state_t;

  state_t        r_state, w_state;
  logic [4:0]    r_gain, w_gain;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [1:0]    r_mode, w_mode;

  logic [9:0]  r_lmix, r_rmix, w_lmix, w_rmix;
  logic [9:0]  r_lpcm, r_rpcm;
  logic [9:0]  r_lacc, r_racc;
  logic        r_lout, r_rout;
  logic [14:0] w_lprod, w_rprod;
  logic [10:0] w_lsum, w_rsum;
  logic [9:0]  w_a, w_b, w_c, w_a2, w_b2, w_c2;
  logic        w_wrap, w_req;
  logic [CW-1:0] w_cnt_inc;

  always_comb begin
    w_a  = {2'b00, a};
    w_b  = {2'b00, b};
    w_c  = {2'b00, c};
    w_a2 = {1'b0, a, 1'b0};
    w_b2 = {1'b0, b, 1'b0};
    w_c2 = {1'b0, c, 1'b0};
    w_lmix = w_a + w_b + w_c;
    w_rmix = w_a + w_b + w_c;
    unique case (r_mode)
      2'b00: begin
        w_lmix = w_a + w_b + w_c;
        w_rmix = w_a + w_b + w_c;
      end
      2'b01: begin
        w_lmix = w_a2 + w_b;
        w_rmix = w_c2 + w_b;
      end
      2'b10: begin
        w_lmix = w_a2 + w_c;
        w_rmix = w_b2 + w_c;
      end
      2'b11: begin
        w_lmix = w_b2 + w_a;
        w_rmix = w_c2 + w_a;
      end
    endcase
  end

  assign w_wrap    = (r_cnt == CMAX);
  assign w_cnt_inc = w_wrap ? '0 : r_cnt + 1'b1;
  assign w_req     = mute || (stereo_mode != r_mode);

  always_comb begin
    w_state = r_state;
    w_gain  = r_gain;
    w_cnt   = r_cnt;
    w_mode  = r_mode;
    if (clken) begin
      unique case (r_state)
        S_RUN: begin
          w_gain = 5'd16;
          if (w_req) begin
            w_state = S_FADE_OUT;
            w_cnt   = '0;
          end
        end
        S_FADE_OUT: begin
          if (r_gain == 5'd0) begin
            w_state = mute ? S_MUTED : S_SWITCH;
          end else begin
            w_cnt = w_cnt_inc;
            if (w_wrap) w_gain = r_gain - 5'd1;
          end
        end
        S_MUTED: begin
          w_gain = 5'd0;
          if (!mute) w_state = S_SWITCH;
        end
        S_SWITCH: begin
          w_mode  = stereo_mode;
          w_state = S_FADE_IN;
          w_cnt   = '0;
        end
        S_FADE_IN: begin
          // Reversal keeps the current gain so the ramp never jumps.
          if (w_req) begin
            w_state = S_FADE_OUT;
            w_cnt   = '0;
          end else if (r_gain == 5'd16) begin
            w_state = S_RUN;
          end else begin
            w_cnt = w_cnt_inc;
            if (w_wrap) w_gain = r_gain + 5'd1;
          end
        end
        default: w_state = S_FADE_IN;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_FADE_IN;
      r_gain  <= 5'd0;
      r_cnt   <= '0;
      r_mode  <= RESET_MODE;
    end else begin
      r_state <= w_state;
      r_gain  <= w_gain;
      r_cnt   <= w_cnt;
      r_mode  <= w_mode;
    end
  end

  assign w_lprod = {5'd0, r_lmix} * {10'd0, r_gain};
  assign w_rprod = {5'd0, r_rmix} * {10'd0, r_gain};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_lmix <= '0;
      r_rmix <= '0;
      r_lpcm <= '0;
      r_rpcm <= '0;
    end else if (clken) begin
      r_lmix <= w_lmix;
      r_rmix <= w_rmix;
      r_lpcm <= 10'(w_lprod >> 4);
      r_rpcm <= 10'(w_rprod >> 4);
    end
  end

  // Carry out of the 10-bit accumulator is the 1-bit DAC sample.
  assign w_lsum = {1'b0, r_lacc} + {1'b0, r_lpcm};
  assign w_rsum = {1'b0, r_racc} + {1'b0, r_rpcm};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_lacc <= '0;
      r_racc <= '0;
      r_lout <= 1'b0;
      r_rout <= 1'b0;
    end else begin
      r_lacc <= w_lsum[9:0];
      r_racc <= w_rsum[9:0];
      r_lout <= w_lsum[10];
      r_rout <= w_rsum[10];
    end
  end

  assign left_pcm  = r_lpcm;
  assign right_pcm = r_rpcm;
  assign left_out  = r_lout;
  assign right_out = r_rout;
  assign busy      = (r_state != S_RUN);

endmodule

// File: tb/tb_psg_stereo_dac.sv
// Directed bench for psg_stereo_dac: fades, mute,
// mode switching, sigma-delta density and async reset.
module tb_psg_stereo_dac;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       clken = 1'b1;
  logic [7:0] a = 8'd255;
  logic [7:0] b = 8'd255;
  logic [7:0] c = 8'd255;
  logic [1:0] stereo_mode = 2'b01;
  logic       mute = 1'b0;
  logic [9:0] left_pcm, right_pcm;
  logic       left_out, right_out, busy;

  int n_pass = 0;
  int n_chk  = 0;

  always #5 clock = ~clock;

  psg_stereo_dac #(
    .RAMP_DIV  (4),
    .RESET_MODE(2'b01)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .clken      (clken),
    .a          (a),
    .b          (b),
    .c          (c),
    .stereo_mode(stereo_mode),
    .mute       (mute),
    .left_pcm   (left_pcm),
    .right_pcm  (right_pcm),
    .left_out   (left_out),
    .right_out  (right_out),
    .busy       (busy)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_idle(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      tick(1);
      if (!busy) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(2);
    n_chk++;
    if ({left_pcm, right_pcm, left_out, right_out, busy} !==
        {10'd0, 10'd0, 1'b0, 1'b0, 1'b1})
      $display("FAIL reset_state got %0d %0d %b %b %b want 0 0 0 0 1",
               left_pcm, right_pcm, left_out, right_out, busy);
    else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_fade_in();
    tick(33);
    n_chk++;
    if (left_pcm !== 10'd382)
      $display("FAIL fadein_mid got %0d want 382", left_pcm);
    else n_pass++;
    tick(31);
    n_chk++;
    if (busy !== 1'b1 || left_pcm !== 10'd717)
      $display("FAIL fadein_64 got busy=%b pcm=%0d want 1 717",
               busy, left_pcm);
    else n_pass++;
    tick(1);
    n_chk++;
    if (busy !== 1'b0 || left_pcm !== 10'd765 || right_pcm !== 10'd765)
      $display("FAIL fadein_done got %b %0d %0d want 0 765 765",
               busy, left_pcm, right_pcm);
    else n_pass++;
  endtask

  task automatic test_run_abc();
    a = 8'd100; b = 8'd50; c = 8'd0;
    tick(1);
    n_chk++;
    if (left_pcm !== 10'd765)
      $display("FAIL abc_latency got %0d want 765", left_pcm);
    else n_pass++;
    tick(1);
    n_chk++;
    if (left_pcm !== 10'd250 || right_pcm !== 10'd50)
      $display("FAIL abc_mix got %0d %0d want 250 50", left_pcm, right_pcm);
    else n_pass++;
  endtask

  task automatic test_clken_hold();
    clken = 1'b0;
    a = 8'd10;
    stereo_mode = 2'b10;
    tick(3);
    n_chk++;
    if (left_pcm !== 10'd250 || right_pcm !== 10'd50 || busy !== 1'b0)
      $display("FAIL clken_hold got %0d %0d busy=%b want 250 50 0",
               left_pcm, right_pcm, busy);
    else n_pass++;
    a = 8'd100;
    stereo_mode = 2'b01;
    clken = 1'b1;
  endtask

  task automatic test_switch();
    int n;
    bit ok;
    logic [9:0] l66, r66;
    n = -1; ok = 1'b1; l66 = 'x; r66 = 'x;
    stereo_mode = 2'b10;
    for (int i = 1; i <= 140; i++) begin
      tick(1);
      if (left_pcm > 10'd250 || right_pcm > 10'd100) ok = 1'b0;
      if (i == 66) begin
        l66 = left_pcm;
        r66 = right_pcm;
      end
      if (!busy) begin
        n = i;
        break;
      end
    end
    n_chk++;
    if (ok !== 1'b1)
      $display("FAIL switch_bound got %b want 1", ok);
    else n_pass++;
    n_chk++;
    if (l66 !== 10'd0 || r66 !== 10'd0)
      $display("FAIL switch_silent got %0d %0d want 0 0", l66, r66);
    else n_pass++;
    n_chk++;
    if (n !== 132)
      $display("FAIL switch_ticks got %0d want 132", n);
    else n_pass++;
    n_chk++;
    if (left_pcm !== 10'd200 || right_pcm !== 10'd100)
      $display("FAIL acb_mix got %0d %0d want 200 100", left_pcm, right_pcm);
    else n_pass++;
  endtask

  task automatic test_mute();
    int n, ol, orr;
    ol = 0; orr = 0;
    mute = 1'b1;
    tick(66);
    n_chk++;
    if (busy !== 1'b1 || left_pcm !== 10'd0 || right_pcm !== 10'd0)
      $display("FAIL mute_zero got busy=%b %0d %0d want 1 0 0",
               busy, left_pcm, right_pcm);
    else n_pass++;
    tick(8);
    for (int i = 0; i < 64; i++) begin
      tick(1);
      ol  += int'(left_out);
      orr += int'(right_out);
    end
    n_chk++;
    if (ol !== 0 || orr !== 0)
      $display("FAIL mute_sd got %0d %0d want 0 0", ol, orr);
    else n_pass++;
    mute = 1'b0;
    wait_idle(100, n);
    n_chk++;
    if (n !== 67 || left_pcm !== 10'd200 || right_pcm !== 10'd100)
      $display("FAIL unmute got ticks=%0d %0d %0d want 67 200 100",
               n, left_pcm, right_pcm);
    else n_pass++;
  endtask

  task automatic test_mute_fadein();
    int n;
    mute = 1'b1;
    tick(66);
    mute = 1'b0;
    tick(38);
    mute = 1'b1;
    tick(1);
    n_chk++;
    if (left_pcm !== 10'd112)
      $display("FAIL fadein_g9 got %0d want 112", left_pcm);
    else n_pass++;
    tick(4);
    n_chk++;
    if (left_pcm !== 10'd112)
      $display("FAIL reverse_hold got %0d want 112", left_pcm);
    else n_pass++;
    tick(1);
    n_chk++;
    if (left_pcm !== 10'd100)
      $display("FAIL reverse_g8 got %0d want 100", left_pcm);
    else n_pass++;
    tick(40);
    n_chk++;
    if (busy !== 1'b1 || left_pcm !== 10'd0)
      $display("FAIL reverse_muted got busy=%b %0d want 1 0",
               busy, left_pcm);
    else n_pass++;
    mute = 1'b0;
    wait_idle(100, n);
    n_chk++;
    if (n !== 67)
      $display("FAIL refade_ticks got %0d want 67", n);
    else n_pass++;
  endtask

  task automatic test_sigma_delta();
    int ol, orr;
    ol = 0; orr = 0;
    a = 8'd128; b = 8'd0; c = 8'd0;
    tick(6);
    n_chk++;
    if (left_pcm !== 10'd256 || right_pcm !== 10'd0)
      $display("FAIL sd_pcm got %0d %0d want 256 0", left_pcm, right_pcm);
    else n_pass++;
    for (int i = 0; i < 1024; i++) begin
      tick(1);
      ol  += int'(left_out);
      orr += int'(right_out);
    end
    n_chk++;
    if (ol !== 256 || orr !== 0)
      $display("FAIL sd_density got %0d %0d want 256 0", ol, orr);
    else n_pass++;
  endtask

  task automatic test_reset_mid_fade();
    int n;
    stereo_mode = 2'b11;
    tick(38);
    n_chk++;
    if (left_pcm !== 10'd112 || busy !== 1'b1)
      $display("FAIL fadeout_g7 got %0d busy=%b want 112 1", left_pcm, busy);
    else n_pass++;
    reset = 1'b1;
    #2;
    n_chk++;
    if ({left_pcm, right_pcm, left_out, right_out, busy} !==
        {10'd0, 10'd0, 1'b0, 1'b0, 1'b1})
      $display("FAIL async_reset got %0d %0d %b %b %b want 0 0 0 0 1",
               left_pcm, right_pcm, left_out, right_out, busy);
    else n_pass++;
    stereo_mode = 2'b01;
    a = 8'd100; b = 8'd50; c = 8'd0;
    tick(1);
    reset = 1'b0;
    wait_idle(100, n);
    n_chk++;
    if (n !== 65 || left_pcm !== 10'd250 || right_pcm !== 10'd50)
      $display("FAIL post_reset got ticks=%0d %0d %0d want 65 250 50",
               n, left_pcm, right_pcm);
    else n_pass++;
  endtask

  task automatic test_modes();
    int n;
    stereo_mode = 2'b11;
    wait_idle(200, n);
    n_chk++;
    if (n !== 132 || left_pcm !== 10'd200 || right_pcm !== 10'd100)
      $display("FAIL bac_mix got ticks=%0d %0d %0d want 132 200 100",
               n, left_pcm, right_pcm);
    else n_pass++;
    stereo_mode = 2'b00;
    wait_idle(200, n);
    n_chk++;
    if (n !== 132 || left_pcm !== 10'd150 || right_pcm !== 10'd150)
      $display("FAIL mono_mix got ticks=%0d %0d %0d want 132 150 150",
               n, left_pcm, right_pcm);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_fade_in();
    test_run_abc();
    test_clken_hold();
    test_switch();
    test_mute();
    test_mute_fadein();
    test_sigma_delta();
    test_reset_mid_fade();
    test_modes();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
